neighbour_window: RTL and testbench

NEIGHBOUR_WINDOW -- requirements
Module: neighbour_window

---
 rtl/neighbour_window.sv | 124 ++++++++++++
 tb/tb_neighbour_window.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neighbour_window.sv
// Frame buffer that replays each loaded cell with its eight neighbours.
// NEIGHBOUR_WINDOW_TORUS_EN: wrap edges toroidally instead of a dead border.
module neighbour_window #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_cell,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_center,
    output logic [7:0]    vecini,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_last
);

    localparam int N  = GRID_W * GRID_H;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    state_t        state;
    logic          armed;
    logic [N-1:0]  fb;
    logic [IW-1:0] widx;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic          emit;

    function automatic logic cell_at(input int cx, input int cy);
        int   px;
        int   py;
        logic ok;
`ifdef NEIGHBOUR_WINDOW_TORUS_EN
        px = (cx + GRID_W) % GRID_W;
        py = (cy + GRID_H) % GRID_H;
        ok = 1'b1;
`else
        px = cx;
        py = cy;
        ok = (cx >= 0) && (cx < GRID_W) && (cy >= 0) && (cy < GRID_H);
`endif
        return ok && fb[IW'(py * GRID_W + px)];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            armed <= 1'b0;
            fb    <= '0;
            widx  <= '0;
            sx    <= '0;
            sy    <= '0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        fb[widx] <= in_cell;
                        if (widx == LAST_IDX) begin
                            widx  <= '0;
                            state <= EMIT;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (sx == XMAX) begin
                            sx <= '0;
                            if (sy == YMAX) begin
                                sy    <= '0;
                                state <= LOAD;
                            end else begin
                                sy <= sy + 1'b1;
                            end
                        end else begin
                            sx <= sx + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign emit      = (state == EMIT);
    assign in_ready  = armed && (state == LOAD);
    assign out_valid = emit;
    assign out_x     = sx;
    assign out_y     = sy;
    assign out_last  = emit && (sx == XMAX) && (sy == YMAX);

    // Window is a pure function of the buffer and scan registers.
    always_comb begin
        vecini     = '0;
        out_center = 1'b0;
        if (emit) begin
            out_center = cell_at(int'(sx), int'(sy));
            vecini[0]  = cell_at(int'(sx) - 1, int'(sy) - 1);
            vecini[1]  = cell_at(int'(sx),     int'(sy) - 1);
            vecini[2]  = cell_at(int'(sx) + 1, int'(sy) - 1);
            vecini[3]  = cell_at(int'(sx) - 1, int'(sy));
            vecini[4]  = cell_at(int'(sx) + 1, int'(sy));
            vecini[5]  = cell_at(int'(sx) - 1, int'(sy) + 1);
            vecini[6]  = cell_at(int'(sx),     int'(sy) + 1);
            vecini[7]  = cell_at(int'(sx) + 1, int'(sy) + 1);
        end
    end

endmodule

// File: tb/tb_neighbour_window.sv
// Scoreboard bench for neighbour_window on the default 8x8 grid.
// Honours NEIGHBOUR_WINDOW_TORUS_EN the same way as the design.
module tb_neighbour_window;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_cell = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_center;
    logic [7:0] vecini;
    logic [2:0] out_x;
    logic [2:0] out_y;
    logic       out_last;

    neighbour_window #(.GRID_W(8), .GRID_H(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_cell(in_cell),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_center(out_center),
        .vecini(vecini),
        .out_x(out_x),
        .out_y(out_y),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

`ifdef NEIGHBOUR_WINDOW_TORUS_EN
    localparam bit TORUS = 1'b1;
`else
    localparam bit TORUS = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       last;
        logic       c;
        logic [7:0] v;
    } exp_t;

    typedef struct {
        int         x;
        int         y;
        logic       c;
        logic [7:0] v;
    } spot_t;

    exp_t  exp_q[$];
    spot_t spots[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic model_cell(input logic [63:0] f, input int x,
                                        input int y);
        logic [63:0] sh;
        int px;
        int py;
        if (TORUS) begin
            px = (x + 8) % 8;
            py = (y + 8) % 8;
        end else begin
            if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b0;
            px = x;
            py = y;
        end
        sh = f >> (py * 8 + px);
        return sh[0];
    endfunction

    task automatic push_frame(input logic [63:0] f);
        exp_t e;
        int   k;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                e.x    = 3'(x);
                e.y    = 3'(y);
                e.last = (x == 7) && (y == 7);
                e.c    = model_cell(f, x, y);
                e.v    = '0;
                k = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0) begin
                            e.v[k] = model_cell(f, x + dx, y + dy);
                            k++;
                        end
                    end
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        check("rst_outputs",
              32'({in_ready, out_valid, out_center, vecini, out_last,
                   out_x, out_y}), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'({in_ready, out_valid}), 32'b10);
    endtask

    task automatic load_frame(input logic [63:0] f, input int count,
                              input bit gaps);
        int   i = 0;
        int   cyc = 0;
        logic rdy;
        logic [63:0] sh;
        while (i < count && cyc < 1000) begin
            cyc++;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            sh       = f >> i;
            in_cell  = sh[0];
            check("load_handshake", 32'({in_ready, out_valid}), 32'b10);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (in_valid && rdy) i++;
        end
        in_valid = 1'b0;
        check("load_done", 32'(i), 32'(count));
        if (count == 64)
            check("ov_rise_after_last_in",
                  32'({in_ready, out_valid}), 32'b01);
    endtask

    task automatic drain(input int duty, input bit poke, input int stop_after);
        int   n = 0;
        int   cyc = 0;
        exp_t e;
        while (n < stop_after && cyc < 2000) begin
            cyc++;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                break;
            end
            out_ready = ($urandom_range(0, 99) < duty);
            if (poke) begin
                in_valid = 1'($urandom_range(0, 1));
                in_cell  = 1'b1;
            end
            e = exp_q[0];
            check("emit_window",
                  32'({out_valid, in_ready, out_x, out_y, out_last,
                       out_center, vecini}),
                  32'({2'b10, e}));
            if (out_ready) begin
                foreach (spots[s]) begin
                    if (spots[s].x == int'(out_x) && spots[s].y == int'(out_y))
                        check("spot_window", 32'({out_center, vecini}),
                              32'({spots[s].c, spots[s].v}));
                end
            end
            @(posedge clk);
            #1;
            if (out_ready) begin
                void'(exp_q.pop_front());
                n++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        spots.delete();
        check("drain_count", 32'(n), 32'(stop_after));
        if (stop_after == 64)
            check("back_to_load", 32'({in_ready, out_valid}), 32'b10);
    endtask

    logic [63:0] f;

    initial begin
        do_reset(3);

        // Blinker
        f = '0;
        f[19] = 1'b1;
        f[27] = 1'b1;
        f[35] = 1'b1;
        load_frame(f, 64, 1'b0);
        push_frame(f);
        spots.push_back('{2, 3, 1'b0, 8'h94});
        spots.push_back('{3, 3, 1'b1, 8'h42});
        drain(100, 1'b0, 64);

        // Lone corner cell
        f = 64'h8000_0000_0000_0000;
        load_frame(f, 64, 1'b1);
        push_frame(f);
        spots.push_back('{0, 0, 1'b0, TORUS ? 8'h01 : 8'h00});
        spots.push_back('{6, 6, 1'b0, 8'h80});
        drain(50, 1'b0, 64);

        // Random frame with in_valid pokes during emit
        f = {$urandom, $urandom};
        load_frame(f, 64, 1'b1);
        push_frame(f);
        drain(50, 1'b1, 64);
        f = {$urandom, $urandom};
        load_frame(f, 64, 1'b0);
        push_frame(f);
        drain(50, 1'b0, 64);

        // Reset mid-scan
        f = {$urandom, $urandom};
        load_frame(f, 64, 1'b0);
        push_frame(f);
        drain(100, 1'b0, 20);
        do_reset(2);

        // Reset mid-load, then all-ones frame
        load_frame(f, 10, 1'b0);
        do_reset(1);
        f = '1;
        load_frame(f, 64, 1'b0);
        push_frame(f);
        spots.push_back('{0, 0, 1'b1, TORUS ? 8'hFF : 8'hD0});
        drain(50, 1'b0, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
